// File: rtl/branch_cmp_pipe.sv
// Two-stage branch comparator: S1 captures the request, S2 holds the resolved outcome.
// Optional statistics counters are enabled by defining BRANCH_CMP_PIPE_STATS_EN.
module branch_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready, ready may depend on out_ready.
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_pred;
  logic             s1_taken;

  logic             s2_valid;
  logic             s2_taken;
  logic             s2_mispredict;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = !flush && s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid && !flush;

  always_comb begin
    s1_taken = 1'b0;
    case (s1_op)
      F3_BEQ:  s1_taken = (s1_a == s1_b);
      F3_BNE:  s1_taken = (s1_a != s1_b);
      F3_BLT:  s1_taken = ($signed(s1_a) <  $signed(s1_b));
      F3_BGE:  s1_taken = ($signed(s1_a) >= $signed(s1_b));
      F3_BLTU: s1_taken = (s1_a <  s1_b);
      F3_BGEU: s1_taken = (s1_a >= s1_b);
      default: s1_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= accept;
    end
  end

  // Payload flops only load on a real transfer, so S2 holds steady under stall.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op   <= in_op;
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_pred <= in_pred_taken;
    end
    if (s2_adv && s1_valid) begin
      s2_taken      <= s1_taken;
      s2_mispredict <= s1_taken ^ s1_pred;
    end
  end

  assign out_taken      = s2_taken;
  assign out_mispredict = s2_mispredict;

`ifdef BRANCH_CMP_PIPE_STATS_EN
  logic             out_hs;
  logic [CNT_W-1:0] cnt_br;
  logic [CNT_W-1:0] cnt_mp;

  assign out_hs = out_valid && out_ready;

  // Saturating counters; a clear in the same cycle as a handshake wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_br <= '0;
      cnt_mp <= '0;
    end else if (stat_clr) begin
      cnt_br <= '0;
      cnt_mp <= '0;
    end else if (out_hs) begin
      if (cnt_br != '1) cnt_br <= cnt_br + 1'b1;
      if (s2_mispredict && (cnt_mp != '1)) cnt_mp <= cnt_mp + 1'b1;
    end
  end

  assign stat_branches    = cnt_br;
  assign stat_mispredicts = cnt_mp;
`else
  logic unused_stat_clr;

  assign unused_stat_clr  = stat_clr;
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
